// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl: shared period counter with NUM_CH compare channels.
// Edge/centre alignment, shadow registers loaded at period boundaries.
module pwm_multi_ctrl #(
    parameter int NUM_CH           = 4,
    parameter int COUNTER_BITWIDTH = 5
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               clk_en_i,
    input  logic                               mode_i,
    input  logic [COUNTER_BITWIDTH:0]          period_i,
    input  logic [NUM_CH*COUNTER_BITWIDTH-1:0] duty_i,
    input  logic [NUM_CH*COUNTER_BITWIDTH-1:0] min_i,
    input  logic [NUM_CH-1:0]                  ch_en_i,
    input  logic                               update_req_i,
    output logic                               update_done_o,
    output logic                               sync_o,
    output logic [NUM_CH-1:0]                  pwm_o
);

    localparam int CW = COUNTER_BITWIDTH;

    logic [CW:0]                     cnt_q, cnt_n;
    logic                            dir_q, dir_n;
    logic                            mode_q, mode_n;
    logic [CW:0]                     p_q, p_n;
    logic [NUM_CH-1:0]               chen_q, chen_n;
    logic [NUM_CH-1:0][CW+1:0]       deff_q, deff_n, deff_in;
    logic                            pend_q, pend_n;
    logic [NUM_CH-1:0]               pwm_n;
    logic                            bnd, load;
    logic [CW+1:0]                   lim;
    logic [NUM_CH-1:0][CW+1:0]       sum;

    // Effective duty per channel from the live inputs, clamped to P_new+1
    always_comb begin
        lim     = {1'b0, period_i} + 1'b1;
        sum     = '0;
        deff_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k] = {2'b00, duty_i[k*CW +: CW]} + {2'b00, min_i[k*CW +: CW]};
            if (duty_i[k*CW +: CW] != '0) begin
                deff_in[k] = (sum[k] > lim) ? lim : sum[k];
            end
        end
    end

    // Counter/direction stepping, boundary detection and shadow load
    always_comb begin
        cnt_n  = cnt_q;
        dir_n  = dir_q;
        mode_n = mode_q;
        p_n    = p_q;
        chen_n = chen_q;
        deff_n = deff_q;
        bnd    = 1'b0;
        load   = 1'b0;
        pend_n = pend_q;
        pwm_n  = '0;
        if (clk_en_i) begin
            if (!mode_q) begin
                bnd   = (cnt_q == p_q);
                cnt_n = bnd ? '0 : cnt_q + 1'b1;
            end else if (!dir_q) begin
                if (cnt_q < p_q) cnt_n = cnt_q + 1'b1;
                else             dir_n = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_n = cnt_q - 1'b1;
            end else begin
                bnd   = 1'b1;
                dir_n = 1'b0;
            end
            load = bnd && (pend_q || update_req_i);
            if (load) begin
                mode_n = mode_i;
                p_n    = period_i;
                chen_n = ch_en_i;
                deff_n = deff_in;
                if (mode_i != mode_q) begin
                    cnt_n = '0;
                    dir_n = 1'b0;
                end
            end
        end
        if (load)              pend_n = 1'b0;
        else if (update_req_i) pend_n = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_n[k] = chen_n[k] && (deff_n[k] != '0) &&
                       ({1'b0, cnt_n} < deff_n[k]);
        end
    end

    // State, shadow and registered output update
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            mode_q        <= 1'b0;
            p_q           <= '0;
            chen_q        <= '0;
            deff_q        <= '0;
            pend_q        <= 1'b0;
            pwm_o         <= '0;
            sync_o        <= 1'b0;
            update_done_o <= 1'b0;
        end else begin
            cnt_q         <= cnt_n;
            dir_q         <= dir_n;
            mode_q        <= mode_n;
            p_q           <= p_n;
            chen_q        <= chen_n;
            deff_q        <= deff_n;
            pend_q        <= pend_n;
            pwm_o         <= pwm_n;
            sync_o        <= bnd;
            update_done_o <= load;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb_pwm_multi_ctrl: vector table, hand sequences and random stimulus
// checked against a phase-position reference model.
module tb_pwm_multi_ctrl;

    localparam int NUM_CH = 4;
    localparam int CW     = 5;

    logic                   clk_i = 1'b0;
    logic                   rstn_i;
    logic                   clk_en_i;
    logic                   mode_i;
    logic [CW:0]            period_i;
    logic [NUM_CH*CW-1:0]   duty_i;
    logic [NUM_CH*CW-1:0]   min_i;
    logic [NUM_CH-1:0]      ch_en_i;
    logic                   update_req_i;
    logic                   update_done_o;
    logic                   sync_o;
    logic [NUM_CH-1:0]      pwm_o;

    pwm_multi_ctrl #(.NUM_CH(NUM_CH), .COUNTER_BITWIDTH(CW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i),
        .mode_i(mode_i), .period_i(period_i), .duty_i(duty_i),
        .min_i(min_i), .ch_en_i(ch_en_i), .update_req_i(update_req_i),
        .update_done_o(update_done_o), .sync_o(sync_o), .pwm_o(pwm_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_mode = 0;

    // Reference model: position within the current period
    int m_pos, m_mode, m_p;
    int m_deff[NUM_CH];
    logic [NUM_CH-1:0] m_chen;
    bit m_pend;
    logic [NUM_CH-1:0] e_pwm;
    bit e_sync, e_done;

    typedef struct {
        bit mode; int p; int duty; int mn; int ch;
        int exp_high; int exp_per;
    } vec_t;
    vec_t vt[6];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int m_len();
        return (m_mode != 0) ? 2 * (m_p + 1) : m_p + 1;
    endfunction

    function automatic int m_cnt();
        if (m_mode != 0 && m_pos > m_p) return 2 * m_p + 1 - m_pos;
        return m_pos;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_mode = 0; m_p = 0; m_chen = '0; m_pend = 0;
        for (int k = 0; k < NUM_CH; k++) m_deff[k] = 0;
        e_pwm = '0; e_sync = 0; e_done = 0;
    endtask

    task automatic step();
        bit bnd, ld;
        int d, mn;
        cyc++;
        case (en_mode)
            0:       clk_en_i = 1'b1;
            1:       clk_en_i = (cyc % 3 == 0);
            default: clk_en_i = ($urandom % 4 != 0);
        endcase
        bnd = 0; ld = 0;
        if (clk_en_i) begin
            bnd = (m_pos == m_len() - 1);
            ld  = bnd && (m_pend || update_req_i);
            if (ld) begin
                m_mode = int'(mode_i);
                m_p    = int'(period_i);
                m_chen = ch_en_i;
                for (int k = 0; k < NUM_CH; k++) begin
                    d  = int'(duty_i[k*CW +: CW]);
                    mn = int'(min_i[k*CW +: CW]);
                    if (d == 0)              m_deff[k] = 0;
                    else if (d + mn > m_p+1) m_deff[k] = m_p + 1;
                    else                     m_deff[k] = d + mn;
                end
            end
            m_pos = bnd ? 0 : m_pos + 1;
        end
        if (ld)                m_pend = 0;
        else if (update_req_i) m_pend = 1;
        e_sync = bnd;
        e_done = ld;
        for (int k = 0; k < NUM_CH; k++)
            e_pwm[k] = m_chen[k] && (m_cnt() < m_deff[k]);
        @(posedge clk_i);
        #1;
        chk("pwm", int'(pwm_o), int'(e_pwm));
        chk("sync", int'(sync_o), int'(e_sync));
        chk("done", int'(update_done_o), int'(e_done));
    endtask

    task automatic set_cfg(bit md, int p, int duty, int mn);
        mode_i   = md;
        period_i = (CW+1)'(p);
        for (int k = 0; k < NUM_CH; k++) begin
            duty_i[k*CW +: CW] = CW'(duty);
            min_i[k*CW +: CW]  = CW'(mn);
        end
        ch_en_i = '1;
    endtask

    task automatic req();
        update_req_i = 1'b1;
        step();
        update_req_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!update_done_o && n < 300) begin step(); n++; end
        if (n >= 300) chk("done_timeout", 0, 1);
    endtask

    task automatic measure(int ch, output int high, output int per);
        int n = 0;
        high = 0; per = 0;
        while (!sync_o && n < 200) begin step(); n++; end
        if (n >= 200) chk("sync_timeout", 0, 1);
        do begin
            high += int'(pwm_o[ch]);
            per++;
            step();
        end while (!sync_o && per < 200);
    endtask

    initial begin
        int hi, per, dn;
        vt[0] = '{0, 9, 3, 2, 0, 5, 10};
        vt[1] = '{1, 9, 4, 0, 1, 8, 20};
        vt[2] = '{0, 9, 31, 31, 2, 10, 10};
        vt[3] = '{0, 9, 0, 7, 3, 0, 10};
        vt[4] = '{1, 3, 1, 1, 0, 4, 8};
        vt[5] = '{0, 0, 1, 0, 1, 1, 1};

        // Reset with nonzero inputs
        rstn_i = 1'b0; clk_en_i = 1'b1; update_req_i = 1'b0;
        set_cfg(1, 9, 5, 3);
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_sync", int'(sync_o), 0);
        chk("rst_done", int'(update_done_o), 0);
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p0_sync", int'(sync_o), 1);
            chk("p0_pwm", int'(pwm_o), 0);
        end

        // Table of configurations
        for (int i = 0; i < 6; i++) begin
            set_cfg(vt[i].mode, vt[i].p, vt[i].duty, vt[i].mn);
            req();
            wait_done();
            measure(vt[i].ch, hi, per);
            chk($sformatf("vec%0d_high", i), hi, vt[i].exp_high);
            chk($sformatf("vec%0d_per", i), per, vt[i].exp_per);
        end

        // Mid-period update with a double request
        set_cfg(0, 19, 2, 0);
        req();
        wait_done();
        measure(2, hi, per);
        chk("mid_old_high", hi, 2);
        repeat (3) step();
        duty_i[2*CW +: CW] = CW'(8);
        req();
        repeat (2) step();
        dn = 0;
        update_req_i = 1'b1;
        step();
        dn += int'(update_done_o);
        update_req_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            dn += int'(update_done_o);
        end
        chk("mid_done_cnt", dn, 1);
        measure(2, hi, per);
        chk("mid_new_high", hi, 8);
        chk("mid_new_per", per, 20);

        // Tick enable every third cycle, then reset with pending update
        en_mode = 1;
        set_cfg(0, 4, 1, 1);
        req();
        wait_done();
        measure(0, hi, per);
        chk("slow_high", hi, 6);
        chk("slow_per", per, 15);
        repeat (3) step();
        duty_i[0 +: CW] = CW'(3);
        req();
        step();
        rstn_i = 1'b0;
        #1;
        model_reset();
        chk("arst_pwm", int'(pwm_o), 0);
        chk("arst_sync", int'(sync_o), 0);
        chk("arst_done", int'(update_done_o), 0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            dn += int'(update_done_o);
        end
        chk("arst_no_done", dn, 0);

        // Random configurations with random tick enable
        en_mode = 2;
        for (int i = 0; i < 25; i++) begin
            mode_i   = 1'($urandom);
            period_i = (CW+1)'($urandom_range(0, 12));
            duty_i   = (NUM_CH*CW)'({$urandom, $urandom});
            min_i    = (NUM_CH*CW)'({$urandom, $urandom});
            ch_en_i  = NUM_CH'($urandom);
            req();
            if ($urandom % 2 == 0) begin
                step();
                update_req_i = 1'b1;
                step();
                update_req_i = 1'b0;
            end
            wait_done();
            repeat ($urandom_range(0, 30)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
